// File: rtl/safety_island_pkg.sv
// Shared types and default SRAM window constants for the safety island memory responder.
package safety_island_pkg;

    localparam logic [31:0] SafetyMemBase = 32'h0000_0000;
    localparam logic [31:0] SafetyMemSize = 32'h0001_0000;

    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } mem_rsp_stage_t;

endpackage

// File: rtl/safety_mem_rsp_pipe.sv
// Fixed-depth shift register carrying {valid,err,we} per granted request so that
// every response leaves exactly Depth cycles after its grant.
module safety_mem_rsp_pipe
    import safety_island_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  mem_rsp_stage_t stage_i,
    output mem_rsp_stage_t stage_o
);

    mem_rsp_stage_t [Depth-1:0] stages_q;
    mem_rsp_stage_t [Depth-1:0] stages_d;

    always_comb begin
        stages_d    = stages_q;
        stages_d[0] = stage_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            stages_d[i] = stages_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stages_q <= '0;
        end else begin
            stages_q <= stages_d;
        end
    end

    assign stage_o = stages_q[Depth-1];

endmodule

// File: rtl/safety_core_mem_responder.sv
// Memory-side responder: forwards in-range core requests to a shared SRAM macro,
// answers faulting requests locally and captures the first faulting address.
module safety_core_mem_responder
    import safety_island_pkg::*;
#(
    parameter int unsigned          AddrWidth    = 32,
    parameter int unsigned          DataWidth    = 32,
    parameter logic [AddrWidth-1:0] MemBaseAddr  = AddrWidth'(SafetyMemBase),
    parameter logic [AddrWidth-1:0] MemSizeBytes = AddrWidth'(SafetyMemSize),
    parameter int unsigned          SramLatency  = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                req_i,
    output logic                                gnt_o,
    input  logic [AddrWidth-1:0]                addr_i,
    input  logic                                we_i,
    input  logic [DataWidth/8-1:0]              be_i,
    input  logic [DataWidth-1:0]                wdata_i,
    output logic                                rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                err_o,
    output logic                                sram_req_o,
    input  logic                                sram_gnt_i,
    output logic                                sram_we_o,
    output logic [DataWidth/8-1:0]              sram_be_o,
    output logic [$clog2(MemSizeBytes)-3:0]     sram_addr_o,
    output logic [DataWidth-1:0]                sram_wdata_o,
    input  logic [DataWidth-1:0]                sram_rdata_i,
    output logic [AddrWidth-1:0]                err_addr_o,
    output logic                                err_valid_o,
    input  logic                                err_clear_i
);

    localparam int unsigned SramAw = $clog2(MemSizeBytes) - 2;
    localparam logic [AddrWidth:0] WinEnd = {1'b0, MemBaseAddr} + {1'b0, MemSizeBytes};
    localparam bit WindowWraps = WinEnd[AddrWidth] && (WinEnd[AddrWidth-1:0] != '0);

    logic [AddrWidth-1:0] offset;
    logic                 in_range;
    logic                 access_ok;
    logic                 req_err;
    logic                 gnt;
    mem_rsp_stage_t       rsp_in;
    mem_rsp_stage_t       rsp_out;
    logic                 err_valid_q, err_valid_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;

    // Unsigned wrap of the subtraction folds "below base" into "beyond size".
    assign offset    = addr_i - MemBaseAddr;
    assign in_range  = offset < MemSizeBytes;
    assign access_ok = in_range & (|be_i);
    assign req_err   = req_i & ~access_ok;
    assign gnt       = req_i & (access_ok ? sram_gnt_i : 1'b1);

    // Outputs are forced low while reset is held, independent of core traffic.
    assign gnt_o        = rst_ni & gnt;
    assign sram_req_o   = rst_ni & req_i & access_ok;
    assign sram_we_o    = rst_ni & we_i;
    assign sram_be_o    = rst_ni ? be_i : '0;
    assign sram_addr_o  = rst_ni ? offset[SramAw+1:2] : '0;
    assign sram_wdata_o = rst_ni ? wdata_i : '0;

    assign rsp_in = '{valid: gnt, err: req_err, we: we_i};

    safety_mem_rsp_pipe #(
        .Depth (SramLatency)
    ) u_rsp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stage_i (rsp_in),
        .stage_o (rsp_out)
    );

    assign rvalid_o = rsp_out.valid;
    assign err_o    = rsp_out.valid & rsp_out.err;
    assign rdata_o  = (rsp_out.valid & ~rsp_out.err & ~rsp_out.we) ? sram_rdata_i : '0;

    // A clear in the same cycle as a new fault drops that fault.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_clear_i) begin
            err_valid_d = 1'b0;
        end else if (gnt && req_err && !err_valid_q) begin
            err_valid_d = 1'b1;
            err_addr_d  = addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt) |=> (req_i && $stable(addr_i) && $stable(we_i)
                             && $stable(be_i) && $stable(wdata_i)));

    a_rvalid_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown(rvalid_o));

    a_window_no_wrap: assert property (@(posedge clk_i) !WindowWraps);

endmodule

// File: tb/tb_safety_core_mem_responder.sv
// Bench for safety_core_mem_responder: one instance at SramLatency=1, one at SramLatency=2,
// each behind a behavioural SRAM macro.
module tb_safety_core_mem_responder;

    localparam logic [31:0] Base = 32'h0000_0000;
    localparam logic [31:0] Size = 32'h0001_0000;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [2], gnt [2], we [2], rvalid [2], err [2];
    logic        sreq [2], sgnt [2], swe [2], evalid [2], eclr [2];
    logic [31:0] addr [2], wdata [2], rdata [2], swdata [2], srdata [2], eaddr [2];
    logic [3:0]  be [2], sbe [2];
    logic [13:0] saddr [2];

    logic [31:0] smem [2][16384];
    logic [31:0] rdp [2][2];
    logic [31:0] ref_mem [int];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    safety_core_mem_responder #(
        .AddrWidth(32), .DataWidth(32), .MemBaseAddr(Base), .MemSizeBytes(Size), .SramLatency(1)
    ) u_dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .err_o(err[0]), .sram_req_o(sreq[0]), .sram_gnt_i(sgnt[0]), .sram_we_o(swe[0]),
        .sram_be_o(sbe[0]), .sram_addr_o(saddr[0]), .sram_wdata_o(swdata[0]),
        .sram_rdata_i(srdata[0]), .err_addr_o(eaddr[0]), .err_valid_o(evalid[0]),
        .err_clear_i(eclr[0])
    );

    safety_core_mem_responder #(
        .AddrWidth(32), .DataWidth(32), .MemBaseAddr(Base), .MemSizeBytes(Size), .SramLatency(2)
    ) u_dut_l2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .err_o(err[1]), .sram_req_o(sreq[1]), .sram_gnt_i(sgnt[1]), .sram_we_o(swe[1]),
        .sram_be_o(sbe[1]), .sram_addr_o(saddr[1]), .sram_wdata_o(swdata[1]),
        .sram_rdata_i(srdata[1]), .err_addr_o(eaddr[1]), .err_valid_o(evalid[1]),
        .err_clear_i(eclr[1])
    );

    // SRAM macro: read data appears SramLatency cycles after a granted access, garbage otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rdp[d][1] <= rdp[d][0];
            rdp[d][0] <= $urandom;
            if (sreq[d] && sgnt[d]) begin
                if (swe[d]) begin
                    for (int b = 0; b < 4; b++)
                        if (sbe[d][b]) smem[d][saddr[d]][8*b +: 8] <= swdata[d][8*b +: 8];
                end else begin
                    rdp[d][0] <= smem[d][saddr[d]];
                end
            end
        end
    end
    assign srdata[0] = rdp[0][0];
    assign srdata[1] = rdp[1][1];

    task automatic drv(input int d, input logic r, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] wd, input logic g);
        req[d] = r; addr[d] = a; we[d] = w; be[d] = b; wdata[d] = wd; sgnt[d] = g;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) drv(d, 1'b1, 32'h10, 1'b1, 4'hF, 32'hA5A5_A5A5, 1'b1);
        repeat (2) next_cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({gnt[d], sreq[d], swe[d], rvalid[d], err[d], evalid[d]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got %b want 000000", d,
                         {gnt[d], sreq[d], swe[d], rvalid[d], err[d], evalid[d]});
            end
            checks++;
            if ({sbe[d], saddr[d], swdata[d], rdata[d], eaddr[d]} !== 114'b0) begin
                errors++;
                $display("FAIL reset_data[%0d]: be=%h addr=%h wdata=%h rdata=%h eaddr=%h want all 0",
                         d, sbe[d], saddr[d], swdata[d], rdata[d], eaddr[d]);
            end
        end
        next_cycle();
        for (int d = 0; d < 2; d++) drv(d, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rvalid[d] !== 1'b0) begin
                errors++; $display("FAIL reset_release_rvalid[%0d]: got %b want 0", d, rvalid[d]);
            end
        end
    endtask

    task automatic test_read_l1();
        next_cycle(); drv(0, 1'b1, 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL t1_wr_gnt: got %b want 1", gnt[0]); end
        next_cycle(); drv(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'h0, 1'b1);
        @(negedge clk);
        checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL t1_rd_gnt: got %b want 1", gnt[0]); end
        checks++; if (sreq[0] !== 1'b1) begin errors++; $display("FAIL t1_sram_req: got %b want 1", sreq[0]); end
        checks++; if (saddr[0] !== 14'd4) begin errors++; $display("FAIL t1_sram_addr: got %h want 4", saddr[0]); end
        checks++;
        if ({rvalid[0], err[0], rdata[0]} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL t1_wr_rsp: rvalid=%b err=%b rdata=%h want 1 0 0", rvalid[0], err[0], rdata[0]);
        end
        next_cycle(); drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if ({rvalid[0], err[0], rdata[0]} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL t1_rd_rsp: rvalid=%b err=%b rdata=%h want 1 0 deadbeef", rvalid[0], err[0], rdata[0]);
        end
        next_cycle(); @(negedge clk);
        checks++; if (rvalid[0] !== 1'b0) begin errors++; $display("FAIL t1_idle_rvalid: got %b want 0", rvalid[0]); end
    endtask

    task automatic test_back_to_back();
        next_cycle(); drv(1, 1'b1, 32'h4, 1'b1, 4'hF, 32'h1234_5678, 1'b1);
        @(negedge clk);
        checks++; if (gnt[1] !== 1'b1) begin errors++; $display("FAIL b2b_wr_gnt: got %b want 1", gnt[1]); end
        next_cycle(); drv(1, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0, 1'b1);
        @(negedge clk);
        checks++; if (gnt[1] !== 1'b1) begin errors++; $display("FAIL b2b_rd_gnt: got %b want 1", gnt[1]); end
        checks++; if (rvalid[1] !== 1'b0) begin errors++; $display("FAIL b2b_early_rvalid: got %b want 0", rvalid[1]); end
        next_cycle(); drv(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if ({rvalid[1], err[1], rdata[1]} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL b2b_wr_rsp: rvalid=%b err=%b rdata=%h want 1 0 0", rvalid[1], err[1], rdata[1]);
        end
        next_cycle(); @(negedge clk);
        checks++;
        if ({rvalid[1], err[1], rdata[1]} !== {2'b10, 32'h1234_5678}) begin
            errors++; $display("FAIL b2b_rd_rsp: rvalid=%b err=%b rdata=%h want 1 0 12345678", rvalid[1], err[1], rdata[1]);
        end
        next_cycle(); @(negedge clk);
        checks++; if (rvalid[1] !== 1'b0) begin errors++; $display("FAIL b2b_idle_rvalid: got %b want 0", rvalid[1]); end
    endtask

    task automatic test_stall();
        next_cycle(); drv(0, 1'b1, 32'h20, 1'b0, 4'hF, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            if (c != 0) next_cycle();
            @(negedge clk);
            checks++;
            if ({gnt[0], sreq[0], rvalid[0]} !== 3'b010) begin
                errors++; $display("FAIL stall_c%0d: gnt=%b sram_req=%b rvalid=%b want 0 1 0", c, gnt[0], sreq[0], rvalid[0]);
            end
        end
        next_cycle(); sgnt[0] = 1'b1;
        @(negedge clk);
        checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL stall_gnt: got %b want 1", gnt[0]); end
        next_cycle(); drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if ({rvalid[0], err[0]} !== 2'b10) begin
            errors++; $display("FAIL stall_rsp: rvalid=%b err=%b want 1 0", rvalid[0], err[0]);
        end
    endtask

    task automatic test_errors();
        next_cycle(); drv(0, 1'b1, 32'h0002_0000, 1'b0, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if ({gnt[0], sreq[0]} !== 2'b10) begin
            errors++; $display("FAIL err_oor_gnt: gnt=%b sram_req=%b want 1 0", gnt[0], sreq[0]);
        end
        next_cycle(); drv(0, 1'b1, 32'h0003_0000, 1'b0, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if ({rvalid[0], err[0], rdata[0]} !== {2'b11, 32'h0}) begin
            errors++; $display("FAIL err_oor_rsp: rvalid=%b err=%b rdata=%h want 1 1 0", rvalid[0], err[0], rdata[0]);
        end
        checks++;
        if ({evalid[0], eaddr[0]} !== {1'b1, 32'h0002_0000}) begin
            errors++; $display("FAIL err_capture: valid=%b addr=%h want 1 00020000", evalid[0], eaddr[0]);
        end
        next_cycle(); drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0); eclr[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({evalid[0], eaddr[0], rvalid[0], err[0]} !== {1'b1, 32'h0002_0000, 2'b11}) begin
            errors++; $display("FAIL err_no_overwrite: valid=%b addr=%h rvalid=%b err=%b want 1 00020000 1 1",
                               evalid[0], eaddr[0], rvalid[0], err[0]);
        end
        next_cycle(); eclr[0] = 1'b0; drv(0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if ({evalid[0], gnt[0], sreq[0]} !== 3'b010) begin
            errors++; $display("FAIL err_be0_req: err_valid=%b gnt=%b sram_req=%b want 0 1 0", evalid[0], gnt[0], sreq[0]);
        end
        next_cycle(); drv(0, 1'b1, 32'h0005_0000, 1'b1, 4'hF, 32'h55, 1'b0); eclr[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({evalid[0], eaddr[0], rvalid[0], err[0], rdata[0]} !== {1'b1, 32'h8, 2'b11, 32'h0}) begin
            errors++; $display("FAIL err_be0_capture: valid=%b addr=%h rvalid=%b err=%b rdata=%h want 1 8 1 1 0",
                               evalid[0], eaddr[0], rvalid[0], err[0], rdata[0]);
        end
        next_cycle(); eclr[0] = 1'b0; drv(0, 1'b1, 32'h0000_FFFC, 1'b0, 4'hF, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if ({evalid[0], rvalid[0], err[0]} !== 3'b011) begin
            errors++; $display("FAIL err_clear_wins: valid=%b rvalid=%b err=%b want 0 1 1", evalid[0], rvalid[0], err[0]);
        end
        checks++;
        if ({gnt[0], sreq[0], saddr[0]} !== {2'b11, 14'h3FFF}) begin
            errors++; $display("FAIL err_top_word: gnt=%b sram_req=%b addr=%h want 1 1 3fff", gnt[0], sreq[0], saddr[0]);
        end
        next_cycle(); drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if ({rvalid[0], err[0]} !== 2'b10) begin
            errors++; $display("FAIL err_top_word_rsp: rvalid=%b err=%b want 1 0", rvalid[0], err[0]);
        end
    endtask

    task automatic test_reset_inflight();
        next_cycle(); drv(1, 1'b1, 32'h0002_0000, 1'b0, 4'hF, 32'h0, 1'b1);
        next_cycle(); drv(1, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if ({gnt[1], evalid[1]} !== 2'b11) begin
            errors++; $display("FAIL rstfl_setup: gnt=%b err_valid=%b want 1 1", gnt[1], evalid[1]);
        end
        next_cycle(); drv(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({rvalid[1], evalid[1]} !== 2'b00) begin
            errors++; $display("FAIL rstfl_during: rvalid=%b err_valid=%b want 0 0", rvalid[1], evalid[1]);
        end
        next_cycle(); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({rvalid[1], evalid[1]} !== 2'b00) begin
                errors++; $display("FAIL rstfl_after_c%0d: rvalid=%b err_valid=%b want 0 0", c, rvalid[1], evalid[1]);
            end
            next_cycle();
        end
    endtask

    task automatic test_random(input int d, input int n);
        exp_t        q[$];
        exp_t        e;
        int          lat;
        int          init_cnt;
        int          widx;
        int          kind;
        logic        held, r, w, g, xerr, xgnt, exp_rv;
        logic [31:0] a, wd, xd;
        logic [3:0]  b;
        lat = (d == 0) ? 1 : 2;
        init_cnt = 0;
        held = 1'b0; r = 1'b0; w = 1'b0; a = 32'h0; wd = 32'h0; b = 4'h0;
        ref_mem.delete();
        for (int i = 0; i < n + 4; i++) begin
            if (!held) begin
                r = 1'b0;
                if (init_cnt < 64) begin
                    widx = (init_cnt == 63) ? 16383 : init_cnt;
                    init_cnt++;
                    r = 1'b1; w = 1'b1; b = 4'hF; a = Base + (32'(widx) << 2); wd = $urandom;
                end else if (i < n && ($urandom % 4) != 0) begin
                    kind = $urandom_range(7, 0);
                    widx = $urandom_range(63, 0);
                    if (widx == 63) widx = 16383;
                    r = 1'b1; w = 1'($urandom); wd = $urandom; b = 4'($urandom_range(15, 1));
                    a = Base + (32'(widx) << 2) + 32'($urandom_range(3, 0));
                    if (kind == 0) a = Base + Size + 32'($urandom_range(15, 0));
                    else if (kind == 1) a = $urandom | 32'h0001_0000;
                    else if (kind == 2) b = 4'h0;
                end
            end
            g = (i >= n) ? 1'b1 : (($urandom % 3) != 0);
            next_cycle(); drv(d, r, a, w, b, wd, g);
            @(negedge clk);
            xerr = !((a - Base) < Size) || (b == 4'h0);
            xgnt = r && (xerr || g);
            checks++;
            if (gnt[d] !== xgnt) begin
                errors++; $display("FAIL rnd%0d_gnt @%0d: got %b want %b (addr=%h be=%h)", d, i, gnt[d], xgnt, a, b);
            end
            checks++;
            if (sreq[d] !== (r && !xerr)) begin
                errors++; $display("FAIL rnd%0d_sram_req @%0d: got %b want %b", d, i, sreq[d], r && !xerr);
            end
            if (r && !xerr) begin
                checks++;
                if (saddr[d] !== 14'((a - Base) >> 2)) begin
                    errors++; $display("FAIL rnd%0d_sram_addr @%0d: got %h want %h", d, i, saddr[d], 14'((a - Base) >> 2));
                end
            end
            exp_rv = (q.size() > 0) && (q[0].cyc + lat == i);
            checks++;
            if (rvalid[d] !== exp_rv) begin
                errors++; $display("FAIL rnd%0d_rvalid @%0d: got %b want %b", d, i, rvalid[d], exp_rv);
            end
            if (rvalid[d] === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({err[d], rdata[d]} !== {e.err, e.data}) begin
                    errors++; $display("FAIL rnd%0d_rsp @%0d: err=%b rdata=%h want err=%b rdata=%h",
                                       d, i, err[d], rdata[d], e.err, e.data);
                end
            end
            if (xgnt) begin
                widx = int'((a - Base) >> 2);
                xd = 32'h0;
                if (!xerr && !w) begin
                    xd = ref_mem[widx];
                end else if (!xerr && w) begin
                    for (int k = 0; k < 4; k++)
                        if (b[k]) ref_mem[widx][8*k +: 8] = wd[8*k +: 8];
                end
                q.push_back('{err: xerr, data: xd, cyc: i});
            end
            held = r && !xgnt;
        end
        drv(d, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL rnd%0d_drain: %0d responses outstanding, want 0", d, q.size());
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            drv(d, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
            eclr[d] = 1'b0;
        end
        test_reset();
        test_read_l1();
        test_back_to_back();
        test_stall();
        test_errors();
        test_reset_inflight();
        test_random(0, 500);
        test_random(1, 500);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000ns, want finished");
        $fatal(1);
    end

endmodule
